// File: rtl/rf_pkg.sv
// rf_pkg
// Shared defaults and helpers for the parametrised register file.
//   RF_DATA_W     default register width
//   RF_NUM_REGS   default register count
//   RF_NUM_RPORTS default read-port count
//   is_zero_reg() true when an index hits the hardwired-zero register
package rf_pkg;

  localparam int RF_DATA_W     = 64;
  localparam int RF_NUM_REGS   = 32;
  localparam int RF_NUM_RPORTS = 2;

  // Register 0 is special only when the zero register is enabled.
  function automatic logic is_zero_reg(input bit zero_reg_en, input logic [31:0] addr);
    return zero_reg_en && (addr == 32'd0);
  endfunction

endpackage

// File: rtl/rf_param_if.sv
// rf_param_if
// Bundles the issue/writeback/read signals of rf_param.
//   master : decode/issue + writeback side (drives indices, writes, allocs, flush)
//   slave  : register file (returns read data, busy flags, busy count)
interface rf_param_if
  import rf_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter int NUM_RPORTS = RF_NUM_RPORTS
);

  logic [NUM_RPORTS*ADDR_W-1:0] rd_addr;
  logic [NUM_RPORTS*DATA_W-1:0] rd_data;
  logic [NUM_RPORTS-1:0]        rd_busy;
  logic                         wr_en;
  logic [ADDR_W-1:0]            wr_addr;
  logic [DATA_W-1:0]            wr_data;
  logic                         alloc_en;
  logic [ADDR_W-1:0]            alloc_addr;
  logic                         flush;
  logic [ADDR_W:0]              busy_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    input  rd_data, rd_busy, busy_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    output rd_data, rd_busy, busy_count
  );

endinterface

// File: rtl/rf_read_port.sv
// rf_read_port
// One combinational read port of rf_param.
//   rd_addr  : register index for this port
//   regs     : full storage array
//   busy     : pending-write flags
//   wr_en/wr_addr/wr_data : current writeback, forwarded when BYPASS=1
//   rd_data  : selected data
//   rd_busy  : pending-write flag of the selected register
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [NUM_REGS-1:0]              busy,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_busy
);

  // Zero register wins over bypass: a write to index 0 is discarded anyway,
  // so forwarding it would expose data that never lands in storage.
  // A forwarded write also reports not-busy, since it is completing now.
  always_comb begin
    rd_data = regs[rd_addr];
    rd_busy = busy[rd_addr];
    if (is_zero_reg(ZERO_REG, 32'(rd_addr))) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end else if (BYPASS && wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/rf_param.sv
// rf_param
// Parametrised multi-port register file with a pending-write scoreboard.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : rf_param_if slave -- read ports, writeback, allocation, flush,
//           per-port busy flags and the count of busy registers
module rf_param
  import rf_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter int NUM_RPORTS = RF_NUM_RPORTS,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input logic   clk,
  input logic   reset,
  rf_param_if.slave bus
);

  localparam int CNT_W = ADDR_W + 1;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy;
  logic [NUM_REGS-1:0]             busy_next;
  logic [CNT_W-1:0]                count;
  logic [CNT_W-1:0]                count_next;
  logic                            wr_valid;
  logic                            alloc_valid;
  logic                            cnt_inc;
  logic                            cnt_dec;

  assign wr_valid    = bus.wr_en    && !is_zero_reg(ZERO_REG, 32'(bus.wr_addr));
  assign alloc_valid = bus.alloc_en && !is_zero_reg(ZERO_REG, 32'(bus.alloc_addr));

  // The counter tracks popcount(busy) incrementally: +1 when an allocation
  // sets a clear bit, -1 when a write clears a set bit that is not being
  // re-allocated in the same cycle. Flush zeroes both outright.
  assign cnt_inc = alloc_valid && !busy[bus.alloc_addr];
  assign cnt_dec = wr_valid && busy[bus.wr_addr] &&
                   !(alloc_valid && (bus.alloc_addr == bus.wr_addr));

  // Order matters: write clear, then allocate set (allocation wins on the
  // same index), then flush overrides both.
  always_comb begin
    busy_next = busy;
    if (wr_valid)    busy_next[bus.wr_addr]    = 1'b0;
    if (alloc_valid) busy_next[bus.alloc_addr] = 1'b1;
    if (bus.flush)   busy_next                 = '0;
    count_next = bus.flush ? '0 : (count + CNT_W'(cnt_inc) - CNT_W'(cnt_dec));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs  <= '0;
      busy  <= '0;
      count <= '0;
    end else begin
      if (wr_valid) regs[bus.wr_addr] <= bus.wr_data;
      busy  <= busy_next;
      count <= count_next;
    end
  end

  logic [NUM_RPORTS*DATA_W-1:0] rd_data_all;
  logic [NUM_RPORTS-1:0]        rd_busy_all;

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
    rf_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .rd_addr (bus.rd_addr[p*ADDR_W +: ADDR_W]),
      .regs    (regs),
      .busy    (busy),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_data (rd_data_all[p*DATA_W +: DATA_W]),
      .rd_busy (rd_busy_all[p])
    );
  end

  assign bus.rd_data    = rd_data_all;
  assign bus.rd_busy    = rd_busy_all;
  assign bus.busy_count = count;

endmodule

// File: doc/rf_param.md
# rf_param

Parametrised multi-port register file with a pending-write scoreboard; next-generation replacement for the fixed 32×64 two-read-port register file in the datapath. Sits between decode/issue (allocation, operand reads) and writeback (register writes). Adds configurable width, depth and read-port count, an optional hardwired-zero register, write-to-read bypass, and per-register busy tracking with a flush.

## Interface
- DATA_W, 64, register width in bits
- NUM_REGS, 32, number of registers (power of two, ≥2)
- ADDR_W, $clog2(NUM_REGS), register index width
- NUM_RPORTS, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and allocations
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RPORTS*ADDR_W  read indices; port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RPORTS*DATA_W  read data; port p at [p*DATA_W +: DATA_W]
- rd_busy  out  NUM_RPORTS  1 = register addressed by port p has a pending write
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback index
- wr_data  in  DATA_W  writeback data
- alloc_en  in  1  issue marks a register as pending
- alloc_addr  in  ADDR_W  register being allocated
- flush  in  1  clears all busy bits (data unchanged)
- busy_count  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage: NUM_REGS × DATA_W registers, busy[NUM_REGS] bits, busy_count counter.
- Reset: all registers 0, all busy 0, busy_count 0; rd_data outputs therefore read 0, rd_busy 0.
- Write: wr_en=1 → reg[wr_addr] ← wr_data at edge and busy[wr_addr] ← 0. ZERO_REG=1 and wr_addr=0 → no effect.
- Allocate: alloc_en=1 → busy[alloc_addr] ← 1. ZERO_REG=1 and alloc_addr=0 → ignored.
- Write and allocate same index same cycle: allocation wins (busy stays/becomes 1; data still written). Different indices: both apply.
- Allocate an already-busy register: stays 1, count unchanged. Write to a non-busy register: count unchanged.
- flush=1: all busy ← 0, busy_count ← 0; overrides alloc_en and the write's busy clear that cycle; the data write still occurs.
- reset has priority over everything.
- Read (combinational) per port p: addr 0 with ZERO_REG → data 0, busy 0. Else if BYPASS and wr_en and wr_addr==rd_addr[p] (and not zero reg) → data wr_data, busy 0. Else data reg[addr], busy busy[addr]. BYPASS=0 → no forwarding; writes visible next cycle.
- rd_busy does not reflect same-cycle alloc_en (visible next cycle).
- busy_count next = count + (alloc sets a previously-clear bit) − (write clears a set bit not re-allocated); never wraps; equals popcount(busy) at all times.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, and from wr_* when BYPASS=1).
- Write/alloc/flush latency: 1 cycle to storage, busy and busy_count.
- No handshake; one write and one allocation per cycle max. No stall outputs.

## Structure
- Package rf_pkg: default parameter constants (RF_DATA_W=64, RF_NUM_REGS=32, RF_NUM_RPORTS=2) and a function for the zero-register check.
- Sub-module rf_read_port: one read port (index mux, zero-reg force, bypass compare), instantiated NUM_RPORTS times via generate.
- Top holds storage array, busy vector, counter.

## Test plan
- Reset → all rd_data 0, rd_busy 0, busy_count 0; write reg 5 = 0xDEAD_BEEF_0123_4567, next cycle port 0 reads it, port 1 on reg 6 reads 0.
- ZERO_REG=1: write reg 0 = 0xFFFF…FF and alloc reg 0 → reads 0, rd_busy 0, busy_count 0.
- BYPASS=1: wr_en reg 7 = 0x55 with rd_addr port1=7 same cycle → rd_data 0x55 that cycle; BYPASS=0 build → old value that cycle, 0x55 next.
- Alloc regs 3,4,9 on consecutive cycles → busy_count 3, rd_busy on 4 = 1; write reg 4 → busy_count 2, rd_busy 0; write+alloc reg 9 same cycle → busy stays 1, count 2.
- Alloc reg 10 with flush asserted and busy regs 3,9 → all busy 0, count 0, data unchanged.
- reset asserted mid-sequence with wr_en and alloc_en active → next cycle all registers 0, busy 0, count 0.
